// File: rtl/mult_booth_ctrl_if.sv
// ============================================================================
//  Module   : mult_booth_ctrl_if
//  Purpose  : Operand/result handshake and shared-adder port bundle for the
//             Booth multiply sequencer. MULT_HI_OUT_EN adds result_hi.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface mult_booth_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] multiplicand;
    logic [WIDTH-1:0] multiplier;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             overflow;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_cin;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;
`ifdef MULT_HI_OUT_EN
    logic [WIDTH-1:0] result_hi;

    modport master (
        output start, multiplicand, multiplier, add_sum, add_cout,
        input  ready, done, result, overflow, result_hi, add_a, add_b, add_cin
    );
    modport slave (
        input  start, multiplicand, multiplier, add_sum, add_cout,
        output ready, done, result, overflow, result_hi, add_a, add_b, add_cin
    );
`else
    modport master (
        output start, multiplicand, multiplier, add_sum, add_cout,
        input  ready, done, result, overflow, add_a, add_b, add_cin
    );
    modport slave (
        input  start, multiplicand, multiplier, add_sum, add_cout,
        output ready, done, result, overflow, add_a, add_b, add_cin
    );
`endif
endinterface

`default_nettype wire

// File: rtl/mult_booth_ctrl.sv
// ============================================================================
//  Module   : mult_booth_ctrl
//  Purpose  : Radix-2 Booth signed multiply sequencer driving an external
//             shared WIDTH-bit adder, one partial-product step per cycle.
//             Optional macro MULT_HI_OUT_EN exposes the product high word.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mult_booth_ctrl #(
    parameter int WIDTH = 32
) (
    input  wire logic          clock,
    input  wire logic          reset,
    mult_booth_ctrl_if.slave   bus
);

    localparam int c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_ready;
    logic               r_done;
    logic [WIDTH-1:0]   r_result;
    logic               r_overflow;
    logic [WIDTH-1:0]   r_p_hi;
    logic [WIDTH-1:0]   r_p_lo;
    logic               r_q_m1;
    logic [WIDTH-1:0]   r_m;
    logic [c_cnt_w-1:0] r_cnt;
`ifdef MULT_HI_OUT_EN
    logic [WIDTH-1:0]   r_result_hi;
    logic               w_unused_cout;
`endif

    logic [WIDTH-1:0]   w_add_a;
    logic [WIDTH-1:0]   w_add_b;
    logic               w_add_cin;
    logic               w_step_ovf;
    logic               w_step_sign;
    logic [WIDTH-1:0]   w_p_hi_nxt;
    logic [WIDTH-1:0]   w_p_lo_nxt;
    logic               w_ovf_nxt;

    // Booth recoding of the current multiplier bit pair selects +M, -M or 0.
    always_comb begin
        w_add_a   = '0;
        w_add_b   = '0;
        w_add_cin = 1'b0;
        if (r_state == S_RUN) begin
            w_add_a = r_p_hi;
            case ({r_p_lo[0], r_q_m1})
                2'b01: w_add_b = r_m;
                2'b10: begin
                    w_add_b   = ~r_m;
                    w_add_cin = 1'b1;
                end
                default: w_add_b = '0;
            endcase
        end
    end

    // The adder is only WIDTH bits wide; recover the true sign of the step
    // from its signed overflow so M = -2^(WIDTH-1) shifts in correctly.
    assign w_step_ovf  = (w_add_a[WIDTH-1] == w_add_b[WIDTH-1]) &&
                         (bus.add_sum[WIDTH-1] != w_add_a[WIDTH-1]);
    assign w_step_sign = bus.add_sum[WIDTH-1] ^ w_step_ovf;
    assign w_p_hi_nxt  = {w_step_sign, bus.add_sum[WIDTH-1:1]};
    assign w_p_lo_nxt  = {bus.add_sum[0], r_p_lo[WIDTH-1:1]};
    assign w_ovf_nxt   = (w_p_hi_nxt != {WIDTH{w_p_lo_nxt[WIDTH-1]}});

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_ready    <= 1'b1;
            r_done     <= 1'b0;
            r_result   <= '0;
            r_overflow <= 1'b0;
            r_p_hi     <= '0;
            r_p_lo     <= '0;
            r_q_m1     <= 1'b0;
            r_m        <= '0;
            r_cnt      <= '0;
`ifdef MULT_HI_OUT_EN
            r_result_hi <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_p_hi  <= '0;
                        r_p_lo  <= bus.multiplier;
                        r_q_m1  <= 1'b0;
                        r_m     <= bus.multiplicand;
                        r_cnt   <= '0;
                        r_ready <= 1'b0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_p_hi <= w_p_hi_nxt;
                    r_p_lo <= w_p_lo_nxt;
                    r_q_m1 <= r_p_lo[0];
                    r_cnt  <= r_cnt + 1'b1;
                    // Final step: capture the product from the post-step
                    // values so result is valid while done is high.
                    if (r_cnt == c_cnt_last) begin
                        r_result   <= w_p_lo_nxt;
                        r_overflow <= w_ovf_nxt;
`ifdef MULT_HI_OUT_EN
                        r_result_hi <= w_p_hi_nxt;
`endif
                        r_done     <= 1'b1;
                        r_state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.ready    = r_ready;
    assign bus.done     = r_done;
    assign bus.result   = r_result;
    assign bus.overflow = r_overflow;
    assign bus.add_a    = w_add_a;
    assign bus.add_b    = w_add_b;
    assign bus.add_cin  = w_add_cin;
`ifdef MULT_HI_OUT_EN
    assign bus.result_hi = r_result_hi;
    assign w_unused_cout = bus.add_cout;
`endif

endmodule

`default_nettype wire
